// File: rtl/keypad_lock_ctrl_if.sv
// rtl/keypad_lock_ctrl_if.sv - key event bus from the keypad encoder to the lock controller
interface keypad_lock_ctrl_if;
  // One-cycle pulse per key press, synchronous to the lock clock
  logic       key_valid;
  // 0-15 hex digit, 16 W (start/commit), 17 X (clear), 18 Y (reprogram), 19 Z (ignored)
  logic [4:0] key_code;

  modport master (output key_valid, output key_code);
  modport slave  (input  key_valid, input  key_code);
endinterface

// File: rtl/keypad_lock_ctrl.sv
// rtl/keypad_lock_ctrl.sv - combination-lock controller: program, verify, lockout, alarm
module keypad_lock_ctrl #(
  parameter int CODE_LEN       = 8,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  keypad_lock_ctrl_if.slave     key_if,
  output logic [2:0]            state_o,
  output logic [3:0]            digit_cnt_o,
  output logic [3:0]            fail_cnt_o,
  output logic [4*CODE_LEN-1:0] entry_o,
  output logic                  open_o,
  output logic                  alarm_o,
  output logic                  lockout_o
);

  localparam int W  = 4 * CODE_LEN;
  // LOCKOUT_CYCLES-1 is the largest value the timer ever holds
  localparam int TW = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [3:0]    LEN_FULL  = 4'(CODE_LEN);
  localparam logic [3:0]    LEN_LAST  = 4'(CODE_LEN - 1);
  localparam logic [3:0]    TRIES_MAX = 4'(MAX_TRIES);
  localparam logic [TW-1:0] TMR_LOAD  = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_ENTRY   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4,
    S_ALARM   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  code_q, code_d;
  logic [W-1:0]  entry_q, entry_d;
  logic [3:0]    digit_cnt_q, digit_cnt_d;
  logic [3:0]    fail_cnt_q, fail_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          open_q, alarm_q, lockout_q;

  logic          kv;
  logic          key_digit, key_w, key_x, key_y;
  logic [W-1:0]  shifted;
  logic [3:0]    fail_inc;

  assign kv        = key_if.key_valid;
  assign key_digit = ~key_if.key_code[4];
  assign key_w     = key_if.key_code == 5'd16;
  assign key_x     = key_if.key_code == 5'd17;
  assign key_y     = key_if.key_code == 5'd18;
  // Newest digit enters at the bottom nibble, oldest falls off the top
  assign shifted   = {entry_q[W-5:0], key_if.key_code[3:0]};
  assign fail_inc  = fail_cnt_q + 4'd1;

  // Next-state and datapath decisions; only key pulses move the machine, apart from the lockout timer
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    entry_d     = entry_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    timer_d     = timer_q;
    case (state_q)
      S_INIT: begin
        if (kv) begin
          if (key_digit && digit_cnt_q < LEN_FULL) begin
            entry_d     = shifted;
            digit_cnt_d = digit_cnt_q + 4'd1;
          end else if (key_x) begin
            entry_d     = '0;
            digit_cnt_d = '0;
          end else if (key_w && digit_cnt_q == LEN_FULL) begin
            code_d      = entry_q;
            entry_d     = '0;
            digit_cnt_d = '0;
            state_d     = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (kv && key_w) begin
          entry_d     = '0;
          digit_cnt_d = '0;
          state_d     = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (kv) begin
          if (key_digit) begin
            if (digit_cnt_q < LEN_LAST) begin
              entry_d     = shifted;
              digit_cnt_d = digit_cnt_q + 4'd1;
            end else begin
              // Whole-code verdict only, so partial entries reveal nothing
              entry_d     = '0;
              digit_cnt_d = '0;
              if (shifted == code_q) begin
                fail_cnt_d = '0;
                state_d    = S_OPEN;
              end else if (fail_inc == TRIES_MAX) begin
                fail_cnt_d = fail_inc;
                state_d    = S_ALARM;
              end else begin
                fail_cnt_d = fail_inc;
                timer_d    = TMR_LOAD;
                state_d    = S_LOCKOUT;
              end
            end
          end else if (key_x) begin
            entry_d     = '0;
            digit_cnt_d = '0;
            state_d     = S_IDLE;
          end else if (key_w) begin
            entry_d     = '0;
            digit_cnt_d = '0;
          end
        end
      end
      S_OPEN: begin
        if (kv && key_w) begin
          state_d = S_IDLE;
        end else if (kv && key_y) begin
          // Old code stays active until the new one is committed with W
          entry_d     = '0;
          digit_cnt_d = '0;
          state_d     = S_INIT;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      S_ALARM: begin
        state_d = S_ALARM;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // State, datapath and flag registers; flags follow the next state so they align with state_o
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      code_q      <= '0;
      entry_q     <= '0;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
      timer_q     <= '0;
      open_q      <= 1'b0;
      alarm_q     <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      entry_q     <= entry_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      timer_q     <= timer_d;
      open_q      <= (state_d == S_OPEN);
      alarm_q     <= (state_d == S_ALARM);
      lockout_q   <= (state_d == S_LOCKOUT);
    end
  end

  assign state_o     = state_q;
  assign digit_cnt_o = digit_cnt_q;
  assign fail_cnt_o  = fail_cnt_q;
  assign entry_o     = entry_q;
  assign open_o      = open_q;
  assign alarm_o     = alarm_q;
  assign lockout_o   = lockout_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb/tb_keypad_lock_ctrl.sv - vector table, corner sequences and random run against a reference model
module tb_keypad_lock_ctrl;

  localparam int CL = 4;
  localparam int MT = 3;
  localparam int LC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  state_o;
  logic [3:0]  digit_cnt_o;
  logic [3:0]  fail_cnt_o;
  logic [15:0] entry_o;
  logic        open_o, alarm_o, lockout_o;

  keypad_lock_ctrl_if kif();

  keypad_lock_ctrl #(.CODE_LEN(CL), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_if      (kif),
    .state_o     (state_o),
    .digit_cnt_o (digit_cnt_o),
    .fail_cnt_o  (fail_cnt_o),
    .entry_o     (entry_o),
    .open_o      (open_o),
    .alarm_o     (alarm_o),
    .lockout_o   (lockout_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: digits kept as a list, code as an integer, lockout as cycles remaining
  int m_state;
  int m_code;
  int m_fail;
  int m_left;
  int m_digits[$];

  function automatic int m_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_code = 0; m_fail = 0; m_left = 0;
    m_digits.delete();
  endtask

  task automatic model_step(input bit v, input int k);
    bit dig;
    dig = (k < 16);
    case (m_state)
      0: if (v) begin
        if (dig && m_digits.size() < CL) m_digits.push_back(k);
        else if (k == 17) m_digits.delete();
        else if (k == 16 && m_digits.size() == CL) begin
          m_code = m_value(); m_digits.delete(); m_state = 1;
        end
      end
      1: if (v && k == 16) begin m_digits.delete(); m_state = 2; end
      2: if (v) begin
        if (dig) begin
          m_digits.push_back(k);
          if (m_digits.size() == CL) begin
            if (m_value() == m_code) begin m_state = 3; m_fail = 0; end
            else if (m_fail + 1 == MT) begin m_fail++; m_state = 5; end
            else begin m_fail++; m_state = 4; m_left = LC; end
            m_digits.delete();
          end
        end else if (k == 17) begin m_digits.delete(); m_state = 1; end
        else if (k == 16) m_digits.delete();
      end
      3: if (v && k == 16) m_state = 1;
         else if (v && k == 18) begin m_digits.delete(); m_state = 0; end
      4: begin m_left--; if (m_left == 0) m_state = 1; end
      default: ;
    endcase
  endtask

  function automatic logic [29:0] pack(input int st, input int dc, input int fl, input int en,
                                       input logic op, input logic al, input logic lk);
    logic [29:0] p;
    p = {3'(st), 4'(dc), 4'(fl), 16'(en), op, al, lk};
    return p;
  endfunction

  function automatic logic [29:0] dut_pack();
    return {state_o, digit_cnt_o, fail_cnt_o, entry_o, open_o, alarm_o, lockout_o};
  endfunction

  task automatic cmp(input string name, input logic [29:0] act, input logic [29:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    cmp(name, dut_pack(),
        pack(m_state, m_digits.size(), m_fail, m_value(), m_state == 3, m_state == 5, m_state == 4));
  endtask

  // Present one cycle of input, advance the model, sample 1 time unit after the edge
  task automatic tick(input bit v, input int k);
    kif.key_valid = v;
    kif.key_code  = 5'(k);
    model_step(v, k);
    @(posedge clk);
    #1;
    kif.key_valid = 1'b0;
  endtask

  task automatic press_seq(input int keys[$]);
    foreach (keys[i]) tick(1'b1, keys[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    cmp("async_reset", dut_pack(), pack(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Wait out a lockout, returning how many sampled cycles lockout_o stayed high
  task automatic wait_lockout(input int first_key, output int n);
    n = 0;
    for (int i = 0; i < 40 && lockout_o; i++) begin
      n++;
      tick(i == 0, first_key);
    end
  endtask

  typedef struct {
    int key; int st; int dc; int fl; int en;
  } vec_t;

  vec_t tbl[$];
  int   n;

  initial begin
    kif.key_valid = 1'b0;
    kif.key_code  = 5'd0;
    model_reset();
    #2;
    do_reset();
    cmp("reset_state", dut_pack(), pack(0, 0, 0, 0, 0, 0, 0));

    // Programming, short-code rejection, IDLE filtering, open, relock, single failure
    tbl = '{
      '{5, 0, 1, 0, 'h5},    '{6, 0, 2, 0, 'h56},   '{16, 0, 2, 0, 'h56},  '{17, 0, 0, 0, 0},
      '{1, 0, 1, 0, 'h1},    '{2, 0, 2, 0, 'h12},   '{3, 0, 3, 0, 'h123},  '{4, 0, 4, 0, 'h1234},
      '{5, 0, 4, 0, 'h1234}, '{16, 1, 0, 0, 0},     '{19, 1, 0, 0, 0},     '{7, 1, 0, 0, 0},
      '{16, 2, 0, 0, 0},     '{1, 2, 1, 0, 'h1},    '{18, 2, 1, 0, 'h1},   '{2, 2, 2, 0, 'h12},
      '{3, 2, 3, 0, 'h123},  '{4, 3, 0, 0, 0},      '{7, 3, 0, 0, 0},      '{16, 1, 0, 0, 0},
      '{16, 2, 0, 0, 0},     '{1, 2, 1, 0, 'h1},    '{2, 2, 2, 0, 'h12},   '{3, 2, 3, 0, 'h123},
      '{5, 4, 0, 1, 0}
    };
    for (int i = 0; i < tbl.size(); i++) begin
      tick(1'b1, tbl[i].key);
      cmp($sformatf("vec%0d", i), dut_pack(),
          pack(tbl[i].st, tbl[i].dc, tbl[i].fl, tbl[i].en,
               tbl[i].st == 3, tbl[i].st == 5, tbl[i].st == 4));
    end

    // Lockout lasts exactly LC cycles and swallows a W pressed inside it
    wait_lockout(16, n);
    cmp("lockout_len", 30'(n), 30'(LC));
    cmp("after_lockout", dut_pack(), pack(1, 0, 1, 0, 0, 0, 0));

    // Two more failures reach ALARM; W is then ignored
    press_seq('{16, 1, 1, 1, 1});
    cmp("fail2", dut_pack(), pack(4, 0, 2, 0, 0, 0, 1));
    wait_lockout(0, n);
    press_seq('{16, 0, 0, 0, 0});
    cmp("alarm", dut_pack(), pack(5, 0, 3, 0, 0, 1, 0));
    tick(1'b1, 16);
    cmp("alarm_sticky", dut_pack(), pack(5, 0, 3, 0, 0, 1, 0));
    do_reset();
    cmp("alarm_reset", dut_pack(), pack(0, 0, 0, 0, 0, 0, 0));

    // Clear, restart, reprogram from OPEN, old code rejected, new code accepted
    press_seq('{1, 2, 3, 4, 16, 16, 1, 2, 17});
    cmp("clear_to_idle", dut_pack(), pack(1, 0, 0, 0, 0, 0, 0));
    press_seq('{16, 1, 16, 1, 2, 3, 4});
    cmp("restart_open", dut_pack(), pack(3, 0, 0, 0, 1, 0, 0));
    press_seq('{18, 9, 9, 9, 9, 16});
    cmp("reprogram", dut_pack(), pack(1, 0, 0, 0, 0, 0, 0));
    press_seq('{16, 1, 2, 3, 4});
    cmp("old_code_fails", dut_pack(), pack(4, 0, 1, 0, 0, 0, 1));
    wait_lockout(0, n);
    press_seq('{16, 9, 9, 9, 9});
    cmp("new_code_opens", dut_pack(), pack(3, 0, 0, 0, 1, 0, 0));
    press_seq('{16, 16, 1, 2});
    cmp("mid_entry", dut_pack(), pack(2, 2, 0, 'h12, 0, 0, 0));
    do_reset();
    cmp("mid_entry_reset", dut_pack(), pack(0, 0, 0, 0, 0, 0, 0));

    // Randomised keys, biased towards the correct next digit so opens and alarms both occur
    for (int i = 0; i < 6000; i++) begin
      int r, k;
      bit v;
      if ((m_state == 5 && $urandom_range(0, 15) == 0) || $urandom_range(0, 999) == 0) begin
        do_reset();
      end
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 99) < 60);
      if (r < 25) k = 16;
      else if (r < 60 && m_state == 2)
        k = (m_code >> (4 * (CL - 1 - m_digits.size()))) & 15;
      else k = $urandom_range(0, 19);
      tick(v, k);
      check_model("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
